// File: rtl/serv_lsu_w_pkg.sv
// Shared types and helpers for the W-bit serial load/store unit.
// Included by the FSM top and the byte-lane datapath.
package serv_lsu_w_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_BUS,
    S_SHIFT_OUT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  function automatic size_e decode_size(input logic word, input logic half);
    if (word) return SZ_WORD;
    else if (half) return SZ_HALF;
    else return SZ_BYTE;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lsb, input size_e size);
    return (lsb[0] & (size != SZ_BYTE)) | (lsb[1] & (size == SZ_WORD));
  endfunction

  function automatic logic [5:0] size_bits(input size_e size);
    case (size)
      SZ_BYTE: return 6'd8;
      SZ_HALF: return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/serv_lsu_w_lane.sv
// Byte-lane steering: rotates store data onto the bus lanes and extracts
// one sign/zero-extended W-bit beat of the load result.
module serv_lsu_w_lane
  import serv_lsu_w_pkg::*;
#(
  parameter int W  = 1,
  parameter int CW = 1
) (
  input  logic [31:0]   data,
  input  logic [1:0]    lsb,
  input  size_e         size,
  input  logic          sgn,
  input  logic [CW-1:0] beat,
  output logic [31:0]   wb_dat,
  output logic [3:0]    wb_sel,
  output logic [W-1:0]  rd
);

  logic [63:0] dbl;
  logic [63:0] rot_l;
  logic [63:0] rot_r;
  logic [4:0]  sh;
  logic [31:0] rd_word;
  logic [5:0]  nbits;
  logic [4:0]  msb;
  logic        ext;
  logic [5:0]  idx;

  // Doubling the word turns the shifts into rotates without a 32-bit shift corner case.
  assign dbl     = {data, data};
  assign sh      = {lsb, 3'b000};
  assign rot_l   = dbl << sh;
  assign rot_r   = dbl >> sh;
  assign wb_dat  = rot_l[63:32];
  assign rd_word = rot_r[31:0];
  assign nbits   = size_bits(size);
  assign msb     = 5'(nbits - 6'd1);
  assign ext     = sgn & rd_word[msb];

  always_comb begin
    wb_sel = 4'hF;
    case (size)
      SZ_BYTE: wb_sel = 4'b0001 << lsb;
      SZ_HALF: wb_sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: wb_sel = 4'hF;
    endcase
  end

  always_comb begin
    rd  = '0;
    idx = '0;
    for (int j = 0; j < W; j++) begin
      idx   = 6'(int'(beat) * W + j);
      rd[j] = (idx < nbits) ? rd_word[idx[4:0]] : ext;
    end
  end

endmodule

// File: rtl/serv_lsu_w.sv
// W-bit serial load/store unit owning the data Wishbone handshake,
// with misalignment trap, bus-error and timeout fault reporting.
module serv_lsu_w
  import serv_lsu_w_pkg::*;
#(
  parameter int W                  = 1,
  parameter bit WITH_MISALIGN_TRAP = 1'b1,
  parameter int TIMEOUT            = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic          i_signed,
  input  logic          i_word,
  input  logic          i_half,
  input  logic [31:0]   i_adr,
  input  logic [W-1:0]  i_op_b,
  output logic          o_op_b_rdy,
  output logic [W-1:0]  o_rd,
  output logic          o_rd_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_misalign,
  output logic          o_fault,
  output logic [31:0]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic          i_wb_err
);

  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [1:0]    lsb_q;
  size_e         size_q;
  logic          sgn_q;
  logic          we_q;
  logic          mis_q;
  logic          fault_q;
  logic [31:0]   data_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;

  size_e         start_size;
  logic          trap;
  logic          beat_last;
  logic          tmo_hit;
  logic          bus_exit;
  logic          bus_fault;
  logic [31+W:0] shift_cat;
  logic [31:0]   lane_dat;
  logic [3:0]    lane_sel;
  logic [W-1:0]  lane_rd;

  assign start_size = decode_size(i_word, i_half);
  assign trap       = WITH_MISALIGN_TRAP && is_misaligned(i_adr[1:0], start_size);
  assign beat_last  = (cnt_q == BEAT_LAST);
  assign tmo_hit    = (TIMEOUT > 0) && (tmo_q == TMO_LAST);
  assign bus_exit   = i_wb_err | i_wb_ack | tmo_hit;
  // err beats ack; ack beats a simultaneous timeout.
  assign bus_fault  = i_wb_err | (~i_wb_ack & tmo_hit);
  assign shift_cat  = {i_op_b, data_q} >> W;

  serv_lsu_w_lane #(.W(W), .CW(CW)) u_lane (
    .data   (data_q),
    .lsb    (lsb_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .beat   (cnt_q),
    .wb_dat (lane_dat),
    .wb_sel (lane_sel),
    .rd     (lane_rd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    o_op_b_rdy = 1'b0;
    o_rd_valid = 1'b0;
    o_wb_cyc   = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = trap ? S_DONE : (i_we ? S_SHIFT_IN : S_BUS);
      end
      S_SHIFT_IN: begin
        o_op_b_rdy = 1'b1;
        if (beat_last) state_d = S_BUS;
      end
      S_BUS: begin
        o_wb_cyc = 1'b1;
        if (bus_exit) state_d = (bus_fault || we_q) ? S_DONE : S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        o_rd_valid = 1'b1;
        if (beat_last) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lsb_q   <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            lsb_q   <= i_adr[1:0];
            size_q  <= start_size;
            sgn_q   <= i_signed;
            we_q    <= i_we;
            mis_q   <= trap;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
          end
        end
        S_SHIFT_IN: begin
          data_q <= shift_cat[31:0];
          cnt_q  <= beat_last ? '0 : cnt_q + 1'b1;
        end
        S_BUS: begin
          tmo_q <= bus_exit ? '0 : tmo_q + 1'b1;
          if (bus_exit) fault_q <= bus_fault;
          if (i_wb_ack && !i_wb_err && !we_q) data_q <= i_wb_rdt;
        end
        S_SHIFT_OUT: begin
          cnt_q <= beat_last ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are parked at zero outside a bus cycle.
  assign o_busy     = (state_q != S_IDLE);
  assign o_misalign = o_done & mis_q;
  assign o_fault    = o_done & fault_q;
  assign o_wb_adr   = o_wb_cyc ? {i_adr[31:2], 2'b00} : '0;
  assign o_wb_dat   = o_wb_cyc ? lane_dat : '0;
  assign o_wb_sel   = o_wb_cyc ? lane_sel : '0;
  assign o_wb_we    = o_wb_cyc & we_q;
  assign o_rd       = o_rd_valid ? lane_rd : '0;

endmodule

// File: tb/tb_serv_lsu_w.sv
// Directed bench for serv_lsu_w with W=4 (8 beats), trap enabled, TIMEOUT=16.
module tb_serv_lsu_w;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start, i_we, i_signed, i_word, i_half;
  logic [31:0] i_adr;
  logic [3:0]  i_op_b;
  logic        o_op_b_rdy;
  logic [3:0]  o_rd;
  logic        o_rd_valid, o_busy, o_done, o_misalign, o_fault;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack, i_wb_err;

  int n_pass  = 0;
  int n_total = 0;

  int          r_done_cyc, r_done_n, r_cyc_n, r_rdy_n, r_rv_n;
  logic        r_fault, r_mis, r_busy_after, r_we;
  logic [31:0] r_rd, r_dat, r_adr;
  logic [3:0]  r_sel;

  always #5 i_clk = ~i_clk;

  serv_lsu_w #(.W(4), .WITH_MISALIGN_TRAP(1'b1), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_we(i_we),
    .i_signed(i_signed), .i_word(i_word), .i_half(i_half), .i_adr(i_adr),
    .i_op_b(i_op_b), .o_op_b_rdy(o_op_b_rdy), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
    .o_busy(o_busy), .o_done(o_done), .o_misalign(o_misalign), .o_fault(o_fault),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  // Runs one transaction; cycle c counts edges from the one that samples i_start.
  task automatic do_txn(input logic we, input logic sgn, input logic word, input logic half,
                        input logic [31:0] adr, input logic [31:0] wdata, input logic [31:0] rdt,
                        input int waits, input logic ack, input logic err, input logic hold);
    int beat_in, beat_out, bus_n, stop_at;
    beat_in = 0; beat_out = 0; bus_n = 0; stop_at = 60;
    r_done_cyc = -1; r_done_n = 0; r_cyc_n = 0; r_rdy_n = 0; r_rv_n = 0;
    r_fault = 0; r_mis = 0; r_busy_after = 1; r_we = 0;
    r_rd = 0; r_dat = 0; r_adr = 0; r_sel = 0;
    @(negedge i_clk);
    i_start = 1; i_we = we; i_signed = sgn; i_word = word; i_half = half;
    i_adr = adr; i_wb_rdt = rdt; i_op_b = '0;
    for (int c = 1; c <= stop_at; c++) begin
      @(posedge i_clk); #1;
      if (!hold) i_start = 0;
      i_wb_ack = 0; i_wb_err = 0;
      if (o_op_b_rdy) begin
        i_op_b = 4'(wdata >> (4 * beat_in));
        beat_in++; r_rdy_n++;
      end
      if (o_rd_valid) begin
        r_rd = r_rd | (32'(o_rd) << (4 * beat_out));
        beat_out++; r_rv_n++;
      end
      if (o_wb_cyc) begin
        r_cyc_n++; r_dat = o_wb_dat; r_adr = o_wb_adr; r_sel = o_wb_sel; r_we = o_wb_we;
        if (bus_n == waits) begin i_wb_ack = ack; i_wb_err = err; end
        bus_n++;
      end
      if (o_done) begin
        r_done_n++;
        if (r_done_cyc < 0) begin
          r_done_cyc = c; r_fault = o_fault; r_mis = o_misalign; stop_at = c + 2;
        end
      end
      if (hold && r_done_cyc >= 0 && c == r_done_cyc + 1) begin
        r_busy_after = o_busy; i_start = 0;
      end
    end
    i_start = 0; i_wb_ack = 0; i_wb_err = 0;
  endtask

  task automatic test_reset;
    i_rst_n = 0; i_start = 1; i_adr = 32'h1234_5678;
    repeat (2) @(posedge i_clk);
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_wb_cyc !== 1'b0) $display("FAIL reset_cyc: got %b want 0", o_wb_cyc); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
    n_total++; if (o_wb_adr !== 32'h0) $display("FAIL reset_adr: got %h want 0", o_wb_adr); else n_pass++;
    n_total++; if (o_wb_sel !== 4'h0) $display("FAIL reset_sel: got %h want 0", o_wb_sel); else n_pass++;
    n_total++; if ({o_op_b_rdy, o_rd_valid, o_rd} !== 6'h0) $display("FAIL reset_beats: got %h want 0", {o_op_b_rdy, o_rd_valid, o_rd}); else n_pass++;
    @(negedge i_clk);
    i_start = 0; i_rst_n = 1;
    @(negedge i_clk);
  endtask

  task automatic test_store_word;
    do_txn(1, 0, 1, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2, 1, 0, 0);
    n_total++; if (r_dat !== 32'hDEAD_BEEF) $display("FAIL stw_dat: got %h want deadbeef", r_dat); else n_pass++;
    n_total++; if (r_sel !== 4'hF) $display("FAIL stw_sel: got %h want f", r_sel); else n_pass++;
    n_total++; if (r_adr !== 32'h100 || r_we !== 1'b1) $display("FAIL stw_adr_we: got %h/%b want 100/1", r_adr, r_we); else n_pass++;
    n_total++; if (r_done_cyc != 12) $display("FAIL stw_latency: got %0d want 12", r_done_cyc); else n_pass++;
    n_total++; if (r_fault !== 1'b0 || r_mis !== 1'b0) $display("FAIL stw_flags: got %b%b want 00", r_fault, r_mis); else n_pass++;
    n_total++; if (r_rdy_n != 8 || r_cyc_n != 3) $display("FAIL stw_counts: got rdy %0d cyc %0d want 8 3", r_rdy_n, r_cyc_n); else n_pass++;
    n_total++; if (r_done_n != 1) $display("FAIL stw_done_pulse: got %0d want 1", r_done_n); else n_pass++;
  endtask

  task automatic test_store_sub;
    do_txn(1, 0, 0, 0, 32'h0000_0102, 32'h0000_00A5, 32'h0, 0, 1, 0, 0);
    n_total++; if (r_dat !== 32'h00A5_0000) $display("FAIL stb_dat: got %h want 00a50000", r_dat); else n_pass++;
    n_total++; if (r_sel !== 4'b0100) $display("FAIL stb_sel: got %b want 0100", r_sel); else n_pass++;
    n_total++; if (r_done_cyc != 10) $display("FAIL stb_latency: got %0d want 10", r_done_cyc); else n_pass++;
    do_txn(1, 0, 0, 1, 32'h0000_0102, 32'h0000_1234, 32'h0, 0, 1, 0, 0);
    n_total++; if (r_dat !== 32'h1234_0000) $display("FAIL sth_dat: got %h want 12340000", r_dat); else n_pass++;
    n_total++; if (r_sel !== 4'b1100) $display("FAIL sth_sel: got %b want 1100", r_sel); else n_pass++;
  endtask

  task automatic test_loads;
    do_txn(0, 1, 0, 0, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1, 0, 0);
    n_total++; if (r_rd !== 32'hFFFF_FF80) $display("FAIL lb_signed: got %h want ffffff80", r_rd); else n_pass++;
    n_total++; if (r_sel !== 4'b1000 || r_we !== 1'b0) $display("FAIL lb_sel_we: got %b/%b want 1000/0", r_sel, r_we); else n_pass++;
    n_total++; if (r_done_cyc != 10 || r_rv_n != 8) $display("FAIL lb_timing: got done %0d beats %0d want 10 8", r_done_cyc, r_rv_n); else n_pass++;
    n_total++; if (r_adr !== 32'h100) $display("FAIL lb_adr: got %h want 100", r_adr); else n_pass++;
    do_txn(0, 0, 0, 1, 32'h0000_0102, 32'h0, 32'h8011_2233, 0, 1, 0, 0);
    n_total++; if (r_rd !== 32'h0000_8011) $display("FAIL lhu: got %h want 00008011", r_rd); else n_pass++;
    n_total++; if (r_sel !== 4'b1100) $display("FAIL lhu_sel: got %b want 1100", r_sel); else n_pass++;
    do_txn(0, 1, 0, 1, 32'h0000_0100, 32'h0, 32'h8011_9234, 0, 1, 0, 0);
    n_total++; if (r_rd !== 32'hFFFF_9234) $display("FAIL lh_signed: got %h want ffff9234", r_rd); else n_pass++;
    do_txn(0, 0, 0, 0, 32'h0000_0101, 32'h0, 32'h8011_2233, 0, 1, 0, 0);
    n_total++; if (r_rd !== 32'h0000_0022) $display("FAIL lbu: got %h want 00000022", r_rd); else n_pass++;
    n_total++; if (r_sel !== 4'b0010) $display("FAIL lbu_sel: got %b want 0010", r_sel); else n_pass++;
  endtask

  task automatic test_misalign;
    do_txn(1, 0, 0, 1, 32'h0000_0101, 32'h0000_5555, 32'h0, 0, 1, 0, 0);
    n_total++; if (r_cyc_n != 0 || r_rdy_n != 0) $display("FAIL mis_sh_nobus: got cyc %0d rdy %0d want 0 0", r_cyc_n, r_rdy_n); else n_pass++;
    n_total++; if (r_mis !== 1'b1 || r_fault !== 1'b0) $display("FAIL mis_sh_flags: got mis %b fault %b want 1 0", r_mis, r_fault); else n_pass++;
    n_total++; if (r_done_cyc != 1) $display("FAIL mis_sh_latency: got %0d want 1", r_done_cyc); else n_pass++;
    do_txn(0, 0, 1, 0, 32'h0000_0102, 32'h0, 32'h0, 0, 1, 0, 0);
    n_total++; if (r_mis !== 1'b1 || r_cyc_n != 0) $display("FAIL mis_lw: got mis %b cyc %0d want 1 0", r_mis, r_cyc_n); else n_pass++;
  endtask

  task automatic test_faults;
    do_txn(0, 0, 1, 0, 32'h0000_0300, 32'h0, 32'h0, 0, 0, 0, 0);
    n_total++; if (r_cyc_n != 16) $display("FAIL tmo_cyc: got %0d want 16", r_cyc_n); else n_pass++;
    n_total++; if (r_done_cyc != 17 || r_fault !== 1'b1) $display("FAIL tmo_done: got cyc %0d fault %b want 17 1", r_done_cyc, r_fault); else n_pass++;
    n_total++; if (r_rv_n != 0) $display("FAIL tmo_nobeats: got %0d want 0", r_rv_n); else n_pass++;
    do_txn(0, 0, 1, 0, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, 1, 1, 1, 0);
    n_total++; if (r_fault !== 1'b1 || r_rv_n != 0) $display("FAIL err_ack: got fault %b beats %0d want 1 0", r_fault, r_rv_n); else n_pass++;
    n_total++; if (r_done_cyc != 3 || r_cyc_n != 2) $display("FAIL err_timing: got done %0d cyc %0d want 3 2", r_done_cyc, r_cyc_n); else n_pass++;
  endtask

  task automatic test_start_held;
    do_txn(1, 0, 1, 0, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 0, 1, 0, 1);
    n_total++; if (r_dat !== 32'h0BAD_F00D) $display("FAIL hold_dat: got %h want 0badf00d", r_dat); else n_pass++;
    n_total++; if (r_done_cyc != 10 || r_done_n != 1) $display("FAIL hold_done: got cyc %0d n %0d want 10 1", r_done_cyc, r_done_n); else n_pass++;
    n_total++; if (r_busy_after !== 1'b0) $display("FAIL hold_idle_after_done: got %b want 0", r_busy_after); else n_pass++;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset_mid_bus;
    logic seen_done;
    seen_done = 0;
    @(negedge i_clk);
    i_start = 1; i_we = 0; i_signed = 0; i_word = 1; i_half = 0; i_adr = 32'h200;
    @(posedge i_clk); #1;
    i_start = 0;
    repeat (3) @(posedge i_clk);
    #1;
    n_total++; if (o_wb_cyc !== 1'b1) $display("FAIL midrst_pre_cyc: got %b want 1", o_wb_cyc); else n_pass++;
    #2 i_rst_n = 0;
    #1;
    n_total++; if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0) $display("FAIL midrst_async: got cyc %b busy %b want 0 0", o_wb_cyc, o_busy); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      if (o_done) seen_done = 1;
    end
    @(negedge i_clk);
    i_rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      if (o_done) seen_done = 1;
    end
    n_total++; if (seen_done !== 1'b0) $display("FAIL midrst_no_done: got %b want 0", seen_done); else n_pass++;
    do_txn(0, 0, 1, 0, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 1, 0, 0);
    n_total++; if (r_rd !== 32'h1234_5678 || r_done_cyc != 10) $display("FAIL midrst_recover: got %h cyc %0d want 12345678 10", r_rd, r_done_cyc); else n_pass++;
  endtask

  initial begin
    i_start = 0; i_we = 0; i_signed = 0; i_word = 0; i_half = 0; i_adr = '0;
    i_op_b = '0; i_wb_rdt = '0; i_wb_ack = 0; i_wb_err = 0; i_rst_n = 0;
    test_reset();
    test_store_word();
    test_store_sub();
    test_loads();
    test_misalign();
    test_faults();
    test_start_held();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
